// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
//   state_t    : arbiter sequencing states (IDLE -> ISSUE -> WAIT -> RESP)
//   owner_t    : which port owns the current memory transaction
//   DEF_ADDR_W : default word-address width
//   DEF_DATA_W : default data width
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority selection between fetch and data ports with a starvation guard.
//   clk, rst_n   : clock, synchronous active-low reset
//   arb_en       : arbiter is in IDLE; a grant taken this cycle updates streak
//   if_req_eff   : fetch request already masked by if_flush
//   dm_req       : data request
//   grant_valid  : some port may be granted this cycle
//   grant_owner  : port that wins (data unless its streak is exhausted)
module mem_arb_prio
  import riscv_mem_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   arb_en,
  input  logic   if_req_eff,
  input  logic   dm_req,
  output logic   grant_valid,
  output owner_t grant_owner
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);

  logic [SW-1:0] streak;

  always_comb begin
    grant_valid = if_req_eff | dm_req;
    grant_owner = OWN_I;
    if (dm_req && (!if_req_eff || (streak < SW'(MAX_DSTREAK))))
      grant_owner = OWN_D;
  end

  // Only contended data grants count; any uncontended grant or fetch grant
  // restarts the streak.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (arb_en && grant_valid) begin
      if (grant_owner == OWN_D && if_req_eff)
        streak <= (streak == SW'(MAX_DSTREAK)) ? streak : streak + SW'(1);
      else
        streak <= '0;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the fetch port (if_*) and the
// load/store port (dm_*). Each access runs ISSUE (one mem_en cycle),
// MEM_LAT WAIT cycles, then a one-cycle RESP carrying the owner's ack.
//   clk, rst_n          : clock, synchronous active-low reset
//   if_req/if_addr      : fetch request, held until if_ack or if_flush
//   if_flush            : cancels pending/in-flight fetch
//   if_ack/if_rdata     : fetch completion pulse and instruction word
//   dm_req/we/be/addr/wdata : data request, held until dm_ack
//   dm_ack/dm_rdata     : data completion pulse and load word
//   mem_en/we/be/addr/wdata : memory strobe and command (registered)
//   mem_rdata           : memory read data, valid MEM_LAT cycles after mem_en
//   busy                : arbiter not in IDLE
module unified_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LAT     = 1,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_t        state;
  owner_t        owner;
  logic          cancel;
  logic [CW-1:0] wcnt;
  logic          grant_valid;
  owner_t        grant_owner;
  logic          if_req_eff;
  logic          arb_en;

  assign if_req_eff = if_req & ~if_flush;
  assign arb_en     = (state == IDLE);

  mem_arb_prio #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_prio (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_en      (arb_en),
    .if_req_eff  (if_req_eff),
    .dm_req      (dm_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_I;
      cancel    <= 1'b0;
      wcnt      <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_ack    <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (grant_valid) begin
            state  <= ISSUE;
            owner  <= grant_owner;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            if (grant_owner == OWN_D) begin
              mem_we    <= dm_we;
              mem_be    <= dm_be;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_be   <= '1;
              mem_addr <= if_addr;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          state <= WAIT;
          wcnt  <= CW'(MEM_LAT);
          if (owner == OWN_I && if_flush)
            cancel <= 1'b1;
        end
        WAIT: begin
          if (owner == OWN_I && if_flush)
            cancel <= 1'b1;
          // The ack is registered, so a flush seen in the final WAIT cycle
          // must suppress it directly rather than through the cancel flag.
          if (wcnt == CW'(1)) begin
            state <= RESP;
            if (owner == OWN_D) begin
              dm_ack <= 1'b1;
              if (!dm_we)
                dm_rdata <= mem_rdata;
            end else if (!(cancel || if_flush)) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            wcnt <= wcnt - CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (owner == OWN_I && if_flush)
            cancel <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_flush;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_checks;
  int n_errors;

  unified_mem_arbiter #(
    .ADDR_W      (10),
    .DATA_W      (32),
    .MEM_LAT     (1),
    .MAX_DSTREAK (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [9:0] a);
    case (a)
      10'h010: word_at = 32'h00500093;
      10'h020: word_at = 32'h11112222;
      10'h030: word_at = 32'h33334444;
      10'h100: word_at = 32'h0BADF00D;
      default: word_at = 32'hC0DE0000 | {22'h0, a};
    endcase
  endfunction

  // One-cycle-latency memory; data is garbage outside the valid cycle.
  always @(posedge clk) begin
    if (mem_en)
      mem_rdata <= word_at(mem_addr);
    else
      mem_rdata <= 32'hEEEEEEEE;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d [6];
    int   n;
    logic gd;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst_n = 1'b1;
    tick();

    // single fetch
    if_req = 1'b1; if_addr = 10'h010;
    chk("sf_busy_c0", busy, 0);
    tick();
    chk("sf_en_c1", mem_en, 1);
    chk("sf_addr_c1", mem_addr, 10'h010);
    chk("sf_we_c1", mem_we, 0);
    chk("sf_be_c1", mem_be, 4'hF);
    chk("sf_busy_c1", busy, 1);
    tick();
    chk("sf_en_c2", mem_en, 0);
    chk("sf_ack_c2", if_ack, 0);
    chk("sf_busy_c2", busy, 1);
    tick();
    chk("sf_ack_c3", if_ack, 1);
    chk("sf_rdata_c3", if_rdata, 32'h00500093);
    chk("sf_dack_c3", dm_ack, 0);
    chk("sf_busy_c3", busy, 1);
    if_req = 1'b0;
    tick();
    chk("sf_ack_c4", if_ack, 0);
    chk("sf_busy_c4", busy, 0);

    // simultaneous requests: data first, then fetch
    if_req = 1'b1; if_addr = 10'h010;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 10'h020;
    tick();
    chk("sim_addr_c1", mem_addr, 10'h020);
    tick(); tick();
    chk("sim_dack_c3", dm_ack, 1);
    chk("sim_iack_c3", if_ack, 0);
    chk("sim_drd_c3", dm_rdata, 32'h11112222);
    dm_req = 1'b0;
    tick(); tick();
    chk("sim_en_c5", mem_en, 1);
    chk("sim_addr_c5", mem_addr, 10'h010);
    tick(); tick();
    chk("sim_iack_c7", if_ack, 1);
    chk("sim_dack_c7", dm_ack, 0);
    chk("sim_ird_c7", if_rdata, 32'h00500093);
    if_req = 1'b0;
    tick();

    // starvation guard with both requests held
    exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    if_req = 1'b1; if_addr = 10'h010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h020;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!mem_en && n < 10) begin tick(); n++; end
      if (!mem_en) begin
        chk("stv_en_timeout", 0, 1);
        break;
      end
      gd = (mem_addr == 10'h020);
      chk($sformatf("stv_order%0d", k), gd, exp_d[k]);
      n = 0;
      while (!(if_ack || dm_ack) && n < 10) begin tick(); n++; end
      chk($sformatf("stv_dack%0d", k), dm_ack, gd);
      chk($sformatf("stv_iack%0d", k), if_ack, !gd);
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick(); tick();
    chk("stv_idle", busy, 0);

    // store
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 10'h040; dm_wdata = 32'hDEADBEEF;
    tick();
    chk("st_en", mem_en, 1);
    chk("st_we", mem_we, 1);
    chk("st_be", mem_be, 4'b0011);
    chk("st_addr", mem_addr, 10'h040);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("st_we_c2", mem_we, 0);
    chk("st_be_hold", mem_be, 4'b0011);
    tick();
    chk("st_ack", dm_ack, 1);
    chk("st_rdata_keep", dm_rdata, 32'h11112222);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();

    // flush in flight
    if_req = 1'b1; if_addr = 10'h010;
    tick(); tick();
    if_flush = 1'b1;
    tick();
    chk("fl_noack_c3", if_ack, 0);
    chk("fl_busy_c3", busy, 1);
    chk("fl_rdata_keep", if_rdata, 32'h00500093);
    if_flush = 1'b0; if_req = 1'b0;
    tick();
    chk("fl_idle_c4", busy, 0);
    chk("fl_noack_c4", if_ack, 0);
    if_req = 1'b1; if_addr = 10'h100;
    tick();
    chk("fl2_addr", mem_addr, 10'h100);
    tick(); tick();
    chk("fl2_ack", if_ack, 1);
    chk("fl2_rdata", if_rdata, 32'h0BADF00D);
    if_req = 1'b0;
    tick();

    // flush in IDLE blocks a fetch grant
    if_req = 1'b1; if_addr = 10'h010; if_flush = 1'b1;
    tick();
    chk("fli_noen", mem_en, 0);
    chk("fli_busy", busy, 0);
    if_req = 1'b0; if_flush = 1'b0;
    tick();

    // reset during WAIT of a data load
    if_req = 1'b1; if_addr = 10'h010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h030;
    tick();
    chk("rs_addr_c1", mem_addr, 10'h030);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rs_busy", busy, 0);
    chk("rs_en", mem_en, 0);
    chk("rs_dack", dm_ack, 0);
    chk("rs_iack", if_ack, 0);
    chk("rs_drd", dm_rdata, 0);
    chk("rs_ird", if_rdata, 0);
    chk("rs_maddr", mem_addr, 0);
    chk("rs_mbe", mem_be, 0);
    chk("rs_mwd", mem_wdata, 0);
    rst_n = 1'b1;
    tick();
    chk("rs_g1_addr", mem_addr, 10'h030);
    tick();
    chk("rs_nodack_wait", dm_ack, 0);
    tick();
    chk("rs_g1_ack", dm_ack, 1);
    chk("rs_g1_rd", dm_rdata, 32'h33334444);
    tick(); tick();
    // streak was cleared by reset, so data wins a second time
    chk("rs_g2_addr", mem_addr, 10'h030);
    if_req = 1'b0; dm_req = 1'b0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
